rtc_bus_sequencer: RTL and testbench

Sequences all bus traffic between the clock/timer user-control logic and the external RTC chip's multiplexed address/data bus. On a write request it snapshots the nine BCD set-values and writes them to the RTC inside a hold/release bracket. On a read request it issues the RTC transfer command, reads the nine time/timer registers back and presents them as a coherent set. It is the only master on the RTC bus; user control and the display path reach the chip only through this block.

---
 rtl/rtc_bus_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_sequencer.sv
// Sole master of the RTC multiplexed address/data bus: runs write bursts (hold, set-values, release)
// and read bursts (transfer command, nine reads), presenting read-back values as one coherent set.
module rtc_bus_sequencer #(
  parameter int PHASE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_req,
  input  logic [1:0] wr_sel,
  input  logic       rd_req,
  input  logic [7:0] diaw,
  input  logic [7:0] mesw,
  input  logic [7:0] annow,
  input  logic [7:0] rhoraw,
  input  logic [7:0] rminw,
  input  logic [7:0] rsegw,
  input  logic [7:0] thoraw,
  input  logic [7:0] tminw,
  input  logic [7:0] tsegw,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anno,
  output logic [7:0] rhora,
  output logic [7:0] rmin,
  output logic [7:0] rseg,
  output logic [7:0] thora,
  output logic [7:0] tmin,
  output logic [7:0] tseg,
  output logic       busy,
  output logic       done,
  output logic       rd_valid,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_GAP, S_DATA, S_REC} state_t;

  localparam logic [7:0] PHASE_LAST = 8'(PHASE_CYC - 1);

  // Handshake: wr_req/rd_req are single-cycle pulses with no ready; each sets a one-deep
  // pending flag that is consumed when its burst leaves IDLE. done/rd_valid are one-cycle pulses.
  state_t     state, state_n;
  logic [7:0] phase;
  logic       phase_last;
  logic [3:0] slot, slot_n, next_slot;
  logic       last_slot;
  logic       burst_rd;
  logic [1:0] burst_sel;
  logic [1:0] sel_q;
  logic       wr_pend, rd_pend;
  logic       start_wr, start_rd, burst_end;
  logic       wr_accept;
  logic [7:0] acc_addr, acc_data;
  logic       acc_read;
  logic [7:0] snap   [9];
  logic [7:0] shadow [9];

  // Slot k (1..9) is one of the nine time/timer registers in burst order.
  function automatic logic [7:0] reg_addr_of(input logic [3:0] k);
    case (k)
      4'd1:    reg_addr_of = 8'h24;
      4'd2:    reg_addr_of = 8'h25;
      4'd3:    reg_addr_of = 8'h26;
      4'd4:    reg_addr_of = 8'h23;
      4'd5:    reg_addr_of = 8'h22;
      4'd6:    reg_addr_of = 8'h21;
      4'd7:    reg_addr_of = 8'h43;
      4'd8:    reg_addr_of = 8'h42;
      4'd9:    reg_addr_of = 8'h41;
      default: reg_addr_of = 8'h00;
    endcase
  endfunction

  assign phase_last = (phase == PHASE_LAST);
  assign wr_accept  = wr_req && (wr_sel != 2'b00);
  assign last_slot  = burst_rd ? (slot == 4'd9) : (slot == 4'd10);
  assign busy       = (state != S_IDLE);
  assign fsm_state  = state;

  // Write bursts skip unselected groups; slot 0 is hold, slot 10 is release.
  always_comb begin
    next_slot = slot + 4'd1;
    if (!burst_rd) begin
      if (next_slot >= 4'd1 && next_slot <= 4'd6 && !burst_sel[0]) next_slot = 4'd7;
      if (next_slot >= 4'd7 && next_slot <= 4'd9 && !burst_sel[1]) next_slot = 4'd10;
    end
  end

  always_comb begin
    acc_addr = 8'h00;
    acc_data = 8'h00;
    acc_read = 1'b0;
    if (slot == 4'd0) begin
      acc_addr = burst_rd ? 8'hF0 : 8'h02;
      acc_data = burst_rd ? 8'hF0 : 8'h10;
    end else if (slot == 4'd10) begin
      acc_addr = 8'h02;
      acc_data = 8'h00;
    end else if (slot <= 4'd9) begin
      acc_addr = reg_addr_of(slot);
      acc_data = snap[slot - 4'd1];
      acc_read = burst_rd;
    end
  end

  always_comb begin
    state_n   = state;
    slot_n    = slot;
    start_wr  = 1'b0;
    start_rd  = 1'b0;
    burst_end = 1'b0;
    cs_n      = 1'b1;
    rd_n      = 1'b1;
    wr_n      = 1'b1;
    a_d       = 1'b1;
    ad_oe     = 1'b0;
    ad_out    = 8'h00;
    case (state)
      S_IDLE: begin
        if (wr_pend) begin
          state_n  = S_ADDR;
          slot_n   = 4'd0;
          start_wr = 1'b1;
        end else if (rd_pend) begin
          state_n  = S_ADDR;
          slot_n   = 4'd0;
          start_rd = 1'b1;
        end
      end
      S_ADDR: begin
        cs_n   = 1'b0;
        a_d    = 1'b0;
        wr_n   = 1'b0;
        ad_oe  = 1'b1;
        ad_out = acc_addr;
        if (phase_last) state_n = S_GAP;
      end
      S_GAP: begin
        cs_n   = 1'b0;
        a_d    = 1'b0;
        ad_oe  = 1'b1;
        ad_out = acc_addr;
        if (phase_last) state_n = S_DATA;
      end
      S_DATA: begin
        cs_n = 1'b0;
        if (acc_read) begin
          rd_n = 1'b0;
        end else begin
          wr_n   = 1'b0;
          ad_oe  = 1'b1;
          ad_out = acc_data;
        end
        if (phase_last) state_n = S_REC;
      end
      S_REC: begin
        if (phase_last) begin
          if (last_slot) begin
            state_n   = S_IDLE;
            burst_end = 1'b1;
          end else begin
            state_n = S_ADDR;
            slot_n  = next_slot;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      phase     <= 8'h00;
      slot      <= 4'd0;
      burst_rd  <= 1'b0;
      burst_sel <= 2'b00;
      sel_q     <= 2'b00;
      wr_pend   <= 1'b0;
      rd_pend   <= 1'b0;
      done      <= 1'b0;
      rd_valid  <= 1'b0;
      dia       <= 8'h00;
      mes       <= 8'h00;
      anno      <= 8'h00;
      rhora     <= 8'h00;
      rmin      <= 8'h00;
      rseg      <= 8'h00;
      thora     <= 8'h00;
      tmin      <= 8'h00;
      tseg      <= 8'h00;
      for (int i = 0; i < 9; i++) begin
        snap[i]   <= 8'h00;
        shadow[i] <= 8'h00;
      end
    end else begin
      state <= state_n;
      slot  <= slot_n;
      phase <= (state == S_IDLE || phase_last) ? 8'h00 : phase + 8'd1;

      // A new request on the consuming edge stays pending for the next burst.
      if (wr_accept) begin
        wr_pend <= 1'b1;
        sel_q   <= wr_sel;
      end else if (start_wr) begin
        wr_pend <= 1'b0;
      end
      if (rd_req)        rd_pend <= 1'b1;
      else if (start_rd) rd_pend <= 1'b0;

      if (start_wr) begin
        burst_rd  <= 1'b0;
        burst_sel <= sel_q;
        snap[0]   <= diaw;
        snap[1]   <= mesw;
        snap[2]   <= annow;
        snap[3]   <= rhoraw;
        snap[4]   <= rminw;
        snap[5]   <= rsegw;
        snap[6]   <= thoraw;
        snap[7]   <= tminw;
        snap[8]   <= tsegw;
      end else if (start_rd) begin
        burst_rd  <= 1'b1;
      end

      if (state == S_DATA && phase_last && acc_read) shadow[slot - 4'd1] <= ad_in;

      done     <= burst_end;
      rd_valid <= burst_end && burst_rd;
      if (burst_end && burst_rd) begin
        dia   <= shadow[0];
        mes   <= shadow[1];
        anno  <= shadow[2];
        rhora <= shadow[3];
        rmin  <= shadow[4];
        rseg  <= shadow[5];
        thora <= shadow[6];
        tmin  <= shadow[7];
        tseg  <= shadow[8];
      end
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: a bus monitor records every RTC access and the reference model
// predicts access lists, burst lengths and read-back sets from the register map.
module tb_rtc_bus_sequencer;

  localparam int P = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_req, rd_req;
  logic [1:0] wr_sel;
  logic [7:0] diaw, mesw, annow, rhoraw, rminw, rsegw, thoraw, tminw, tsegw;
  logic [7:0] ad_in, ad_out;
  logic       ad_oe, cs_n, rd_n, wr_n, a_d;
  logic [7:0] dia, mes, anno, rhora, rmin, rseg, thora, tmin, tseg;
  logic       busy, done, rd_valid;
  logic [2:0] fsm_state;

  always #5 clk = ~clk;

  rtc_bus_sequencer #(.PHASE_CYC(P)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_sel(wr_sel), .rd_req(rd_req),
    .diaw(diaw), .mesw(mesw), .annow(annow), .rhoraw(rhoraw), .rminw(rminw),
    .rsegw(rsegw), .thoraw(thoraw), .tminw(tminw), .tsegw(tsegw),
    .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n),
    .wr_n(wr_n), .a_d(a_d), .dia(dia), .mes(mes), .anno(anno), .rhora(rhora),
    .rmin(rmin), .rseg(rseg), .thora(thora), .tmin(tmin), .tseg(tseg),
    .busy(busy), .done(done), .rd_valid(rd_valid), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;

  logic [7:0]  reg_addr [9] = '{8'h24, 8'h25, 8'h26, 8'h23, 8'h22, 8'h21, 8'h43, 8'h42, 8'h41};
  logic [16:0] exp_q[$];
  logic [16:0] obs_q[$];
  int          exp_len_q[$];
  int          run_q[$];
  logic [71:0] rb_exp;
  logic [71:0] rb_now;
  logic [7:0]  rd_key;
  logic [7:0]  bus_addr = 8'h00;

  assign rb_now = {tseg, tmin, thora, rseg, rmin, rhora, anno, mes, dia};
  assign ad_in  = bus_addr ^ rd_key;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_write(input logic [1:0] sel, input logic [71:0] vals);
    int n;
    n = 2;
    exp_q.push_back({1'b0, 8'h02, 8'h10});
    if (sel[0]) begin
      for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, reg_addr[i], vals[i*8 +: 8]});
      n += 6;
    end
    if (sel[1]) begin
      for (int i = 6; i < 9; i++) exp_q.push_back({1'b0, reg_addr[i], vals[i*8 +: 8]});
      n += 3;
    end
    exp_q.push_back({1'b0, 8'h02, 8'h00});
    exp_len_q.push_back(n * 4 * P);
  endtask

  task automatic model_read(input logic [7:0] key);
    exp_q.push_back({1'b0, 8'hF0, 8'hF0});
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back({1'b1, reg_addr[i], reg_addr[i] ^ key});
      rb_exp[i*8 +: 8] = reg_addr[i] ^ key;
    end
    exp_len_q.push_back(10 * 4 * P);
  endtask

  // ---------------- bus model and monitor ----------------
  int          done_cnt = 0, rdv_cnt = 0, rdv_done_idx = 0;
  int          prot_err = 0, tear_err = 0, run_len = 0;
  logic        mon_active = 1'b0, mon_rd = 1'b0, prev_done = 1'b0;
  logic [7:0]  mon_addr = 8'h00, mon_data = 8'h00;
  logic [71:0] prev_rb = '0;

  always @(negedge clk) begin
    if (!cs_n && !a_d && !wr_n) bus_addr = ad_out;
  end

  always @(negedge clk) begin
    if (reset) begin
      mon_active = 1'b0;
      run_len    = 0;
      obs_q.delete();
      run_q.delete();
      prev_rb    = rb_now;
      prev_done  = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        if (prev_done || busy) prot_err++;
      end
      if (rd_valid) begin
        rdv_cnt++;
        rdv_done_idx = done_cnt;
        if (!done) prot_err++;
      end
      if (rb_now !== prev_rb && !rd_valid) tear_err++;
      prev_rb   = rb_now;
      prev_done = done;
      if (busy) run_len++;
      else if (run_len != 0) begin
        run_q.push_back(run_len);
        run_len = 0;
      end
      if (!cs_n) begin
        if (!busy || ad_oe !== rd_n) prot_err++;
        mon_active = 1'b1;
        if (!a_d && !wr_n) begin
          mon_addr = ad_out;
          mon_rd   = 1'b0;
        end
        if (a_d && !wr_n) mon_data = ad_out;
        if (a_d && !rd_n) begin
          mon_rd   = 1'b1;
          mon_data = ad_in;
        end
      end else begin
        if (ad_oe) prot_err++;
        if (mon_active) obs_q.push_back({mon_rd, mon_addr, mon_data});
        mon_active = 1'b0;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic set_inputs(input logic [71:0] v);
    diaw = v[7:0];   mesw = v[15:8];  annow = v[23:16];
    rhoraw = v[31:24]; rminw = v[39:32]; rsegw = v[47:40];
    thoraw = v[55:48]; tminw = v[63:56]; tsegw = v[71:64];
  endtask

  task automatic pulse_req(input logic w, input logic [1:0] sel, input logic r);
    @(negedge clk);
    wr_req = w;
    wr_sel = sel;
    rd_req = r;
    @(negedge clk);
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int n;
    n = 0;
    while (done_cnt < target && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    check(tag, 72'(done_cnt >= target), 72'd1);
    @(negedge clk); #1;
  endtask

  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    while (!busy && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check(tag, 72'(busy), 72'd1);
  endtask

  task automatic compare_all(input string tag);
    logic [16:0] e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 17'h1FFFF;
      check({tag, "_access"}, 72'(o), 72'(e));
    end
    check({tag, "_extra_acc"}, 72'(obs_q.size()), 72'd0);
    obs_q.delete();
    while (exp_len_q.size() > 0) begin
      check({tag, "_busy_len"}, 72'((run_q.size() > 0) ? run_q.pop_front() : -1),
            72'(exp_len_q.pop_front()));
    end
    check({tag, "_extra_burst"}, 72'(run_q.size()), 72'd0);
    run_q.delete();
  endtask

  // ---------------- stimulus ----------------
  logic [71:0] v, v2;
  logic [1:0]  sel, sel2;
  int          d0, r0, bcnt;
  logic        found;

  initial begin
    reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wr_sel = 2'b00; rd_key = 8'h80;
    set_inputs('0);
    repeat (3) @(negedge clk);
    #1;
    check("reset_bus", {cs_n, rd_n, wr_n, a_d, ad_oe, ad_out}, {5'b11110, 8'h00});
    check("reset_status", {busy, done, rd_valid}, 3'b000);
    check("reset_readback", rb_now, 72'h0);
    @(negedge clk);
    reset = 1'b0;

    // Directed write, both groups, with start latency.
    v = {8'h03, 8'h02, 8'h01, 8'h30, 8'h59, 8'h23, 8'h16, 8'h09, 8'h15};
    set_inputs(v);
    model_write(2'b11, v);
    d0 = done_cnt;
    @(negedge clk);
    wr_sel = 2'b11; wr_req = 1'b1;
    @(posedge clk); #1;
    wr_req = 1'b0;
    check("latency_edge_n", 72'(busy), 72'd0);
    @(posedge clk); #1;
    check("latency_edge_n1", 72'(busy), 72'd1);
    wait_done(d0 + 1, "wr_both_done");
    compare_all("wr_both");
    repeat (5) @(negedge clk);
    #1;
    check("wr_both_one_done", 72'(done_cnt - d0), 72'd1);

    // Timer-only write.
    v = {8'($urandom), 32'($urandom), 32'($urandom)};
    set_inputs(v);
    model_write(2'b10, v);
    d0 = done_cnt;
    pulse_req(1'b1, 2'b10, 1'b0);
    wait_done(d0 + 1, "wr_timer_done");
    compare_all("wr_timer");

    // Directed read: the bus returns address ^ 0x80.
    rd_key = 8'h80;
    model_read(rd_key);
    d0 = done_cnt; r0 = rdv_cnt;
    pulse_req(1'b0, 2'b00, 1'b1);
    wait_done(d0 + 1, "rd_done");
    compare_all("rd");
    check("rd_dia", 72'(dia), 72'hA4);
    check("rd_tseg", 72'(tseg), 72'hC1);
    check("rd_set", rb_now, rb_exp);
    check("rd_valid_cnt", 72'(rdv_cnt - r0), 72'd1);

    // Simultaneous write and read: write first, rd_valid only with the second done.
    v = {8'($urandom), 32'($urandom), 32'($urandom)};
    sel = 2'($urandom_range(1, 3));
    rd_key = 8'($urandom);
    set_inputs(v);
    model_write(sel, v);
    model_read(rd_key);
    d0 = done_cnt; r0 = rdv_cnt;
    pulse_req(1'b1, sel, 1'b1);
    wait_done(d0 + 2, "both_done");
    compare_all("both");
    check("both_rdv_cnt", 72'(rdv_cnt - r0), 72'd1);
    check("both_rdv_second", 72'(rdv_done_idx), 72'(d0 + 2));
    check("both_set", rb_now, rb_exp);

    // Write request during a write burst is queued and runs afterwards.
    v = {8'($urandom), 32'($urandom), 32'($urandom)};
    sel = 2'($urandom_range(1, 3));
    set_inputs(v);
    model_write(sel, v);
    d0 = done_cnt;
    pulse_req(1'b1, sel, 1'b0);
    wait_busy("queued_start");
    repeat (6) @(negedge clk);
    v2 = {8'($urandom), 32'($urandom), 32'($urandom)};
    sel2 = 2'($urandom_range(1, 3));
    set_inputs(v2);
    model_write(sel2, v2);
    pulse_req(1'b1, sel2, 1'b0);
    wait_done(d0 + 2, "queued_done");
    compare_all("queued");

    // Snapshot: diaw changes mid-burst must not reach the bus.
    v = {8'($urandom), 32'($urandom), 32'($urandom)};
    set_inputs(v);
    model_write(2'b11, v);
    d0 = done_cnt;
    pulse_req(1'b1, 2'b11, 1'b0);
    wait_busy("snap_start");
    repeat (10) @(negedge clk);
    diaw = ~v[7:0];
    mesw = ~v[15:8];
    wait_done(d0 + 1, "snap_done");
    compare_all("snap");

    // wr_sel = 00 is ignored entirely.
    d0 = done_cnt;
    pulse_req(1'b1, 2'b00, 1'b0);
    bcnt = 0;
    repeat (30) begin
      @(negedge clk); #1;
      if (busy) bcnt++;
    end
    check("ignore_busy", 72'(bcnt), 72'd0);
    check("ignore_done", 72'(done_cnt - d0), 72'd0);
    check("ignore_acc", 72'(obs_q.size()), 72'd0);

    // Randomized mix of requests.
    for (int it = 0; it < 10; it++) begin
      d0 = done_cnt;
      if ($urandom_range(0, 1) == 1) begin
        v = {8'($urandom), 32'($urandom), 32'($urandom)};
        sel = 2'($urandom_range(0, 3));
        set_inputs(v);
        if (sel != 2'b00) model_write(sel, v);
        pulse_req(1'b1, sel, 1'b0);
        if (sel == 2'b00) begin
          repeat (20) @(negedge clk);
          #1;
          check("rand_ignore_done", 72'(done_cnt - d0), 72'd0);
        end else begin
          wait_done(d0 + 1, "rand_wr_done");
        end
        compare_all("rand_wr");
      end else begin
        rd_key = 8'($urandom);
        model_read(rd_key);
        pulse_req(1'b0, 2'b00, 1'b1);
        wait_done(d0 + 1, "rand_rd_done");
        compare_all("rand_rd");
        check("rand_rd_set", rb_now, rb_exp);
      end
    end

    // Reset during a read DATA phase releases the bus at once and produces no pulses.
    rd_key = 8'($urandom);
    d0 = done_cnt; r0 = rdv_cnt;
    pulse_req(1'b0, 2'b00, 1'b1);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk); #1;
      if (!cs_n && a_d && !rd_n) found = 1'b1;
    end
    check("rst_found_data", 72'(found), 72'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_bus_release", {cs_n, ad_oe, busy}, 3'b100);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    #1;
    check("rst_no_done", 72'(done_cnt - d0), 72'd0);
    check("rst_no_rdv", 72'(rdv_cnt - r0), 72'd0);
    check("rst_readback", rb_now, 72'h0);
    check("rst_idle", 72'(busy), 72'd0);
    check("rst_no_acc", 72'(obs_q.size()), 72'd0);

    check("protocol_errors", 72'(prot_err), 72'd0);
    check("torn_readback", 72'(tear_err), 72'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
